nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 100 ++++++++++
 tb/tb_nibble_serial_adder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice, one nibble per clock (LSB first),
// carry chained through a register, valid/ready handshakes on both sides.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] op_a_reg, op_b_reg, sum_reg, sum_next;
  logic             carry_reg, carry_out_reg;
  logic [CW-1:0]    nib_cnt_reg;
  logic [4:0]       slice;
  logic             accept, last_step;

  // Single 4-bit slice with carry-in; slice[4] is the nibble carry-out.
  assign slice     = {1'b0, op_a_reg[3:0]} + {1'b0, op_b_reg[3:0]} + {4'b0, carry_reg};
  assign last_step = (nib_cnt_reg == LAST_NIB);

  // New nibble enters the sum from the top; a single-nibble sum is just the slice.
  generate
    if (WIDTH == 4) begin : g_one_nib
      assign sum_next = slice[3:0];
    end else begin : g_multi_nib
      assign sum_next = {slice[3:0], sum_reg[WIDTH-1:4]};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      nib_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_a_reg    <= a;
        op_b_reg    <= b;
        carry_reg   <= 1'b0;
        nib_cnt_reg <= '0;
      end else if (state_reg == RUN) begin
        op_a_reg    <= op_a_reg >> 4;
        op_b_reg    <= op_b_reg >> 4;
        sum_reg     <= sum_next;
        carry_reg   <= slice[4];
        nib_cnt_reg <= nib_cnt_reg + CW'(1);
        if (last_step) carry_out_reg <= slice[4];
      end
    end
  end

  assign sum       = sum_reg;
  assign carry_out = carry_out_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: WIDTH=16 and WIDTH=4 instances checked every cycle
// against a transaction-level model (a+b, N-cycle latency), plus directed literals.
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid[2], out_ready[2];
  logic        in_ready[2], out_valid[2], carry_out[2], busy[2];
  logic [15:0] a[2], b[2], sum_w[2];
  logic [15:0] sum16;
  logic [3:0]  sum4;
  int          n_vec = 0, n_err = 0, cyc = 0;

  // Model: operation in flight, edges since accept, expected result.
  bit          m_inflight[2] = '{0, 0};
  int          m_age[2] = '{0, 0};
  logic [15:0] m_sum[2];
  logic        m_cout[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum16), .carry_out(carry_out[0]), .busy(busy[0])
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1][3:0]), .b(b[1][3:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum4), .carry_out(carry_out[1]), .busy(busy[1])
  );

  assign sum_w[0] = sum16;
  assign sum_w[1] = {12'h000, sum4};

  function automatic int nsteps(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int wbits(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic plus the handshake timeline.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_inflight[k] = 0;
        m_age[k]      = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!m_inflight[k]) begin
          if (in_valid[k] === 1'b1) begin
            logic [16:0] mask, full;
            mask          = (17'h1 << wbits(k)) - 17'h1;
            full          = ({1'b0, a[k]} & mask) + ({1'b0, b[k]} & mask);
            m_sum[k]      = full[15:0] & mask[15:0];
            m_cout[k]     = full[wbits(k)];
            m_inflight[k] = 1;
            m_age[k]      = 0;
          end
        end else if (m_age[k] < nsteps(k)) begin
          m_age[k]++;
        end else if (out_ready[k] === 1'b1) begin
          m_inflight[k] = 0;
        end
      end
    end
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit exp_ov;
      exp_ov = m_inflight[k] && (m_age[k] == nsteps(k));
      chk($sformatf("w%0d in_ready", wbits(k)), 32'(in_ready[k]), 32'(!m_inflight[k]));
      chk($sformatf("w%0d busy", wbits(k)), 32'(busy[k]),
          32'(m_inflight[k] && (m_age[k] < nsteps(k))));
      chk($sformatf("w%0d out_valid", wbits(k)), 32'(out_valid[k]), 32'(exp_ov));
      if (exp_ov) begin
        chk($sformatf("w%0d sum", wbits(k)), 32'(sum_w[k]), 32'(m_sum[k]));
        chk($sformatf("w%0d carry_out", wbits(k)), 32'(carry_out[k]), 32'(m_cout[k]));
      end
    end
  end

  function automatic logic [15:0] pick();
    case ($urandom % 4)
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Entered and left at posedge+2.
  task automatic issue(input int k, input logic [15:0] av, input logic [15:0] bv,
                       output int acc);
    int t;
    t = 0;
    while (in_ready[k] !== 1'b1 && t < 40) begin
      @(posedge clk); #2;
      t++;
    end
    chk("in_ready before issue", 32'(in_ready[k]), 32'd1);
    in_valid[k] = 1'b1;
    a[k] = av;
    b[k] = bv;
    @(posedge clk); #1;
    acc = cyc;
    #1;
    in_valid[k] = 1'b0;
    a[k] = 16'($urandom);
    b[k] = 16'($urandom);
  endtask

  task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input int hold, input logic [15:0] es, input logic ec,
                       input bit pulse, output int acc);
    int lat;
    issue(k, av, bv, acc);
    lat = 0;
    while (out_valid[k] !== 1'b1 && lat < 40) begin
      if (pulse) begin
        in_valid[k] = 1'($urandom);
        a[k] = 16'($urandom);
        b[k] = 16'($urandom);
      end
      @(posedge clk); #2;
      lat++;
    end
    in_valid[k] = 1'b0;
    chk("latency", 32'(lat), 32'(nsteps(k)));
    chk("literal sum", 32'(sum_w[k]), 32'(es));
    chk("literal carry_out", 32'(carry_out[k]), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      chk("held out_valid", 32'(out_valid[k]), 32'd1);
      chk("held in_ready", 32'(in_ready[k]), 32'd0);
      chk("held sum", 32'(sum_w[k]), 32'(es));
      chk("held carry_out", 32'(carry_out[k]), 32'(ec));
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #2;
    out_ready[k] = 1'b0;
    chk("in_ready after handshake", 32'(in_ready[k]), 32'd1);
    chk("out_valid after handshake", 32'(out_valid[k]), 32'd0);
  endtask

  initial begin
    int acc1, acc2;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      a[k] = 16'h0;
      b[k] = 16'h0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset in_ready", 32'(in_ready[k]), 32'd1);
      chk("reset out_valid", 32'(out_valid[k]), 32'd0);
      chk("reset busy", 32'(busy[k]), 32'd0);
      chk("reset sum", 32'(sum_w[k]), 32'd0);
      chk("reset carry_out", 32'(carry_out[k]), 32'd0);
    end
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    do_op(0, 16'h1234, 16'h4321, 0, 16'h5555, 1'b0, 1'b0, acc1);
    do_op(0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1'b1, 1'b0, acc1);
    // Back-to-back with ignored in_valid pulses while running.
    do_op(0, 16'h00FF, 16'h0F01, 0, 16'h1000, 1'b0, 1'b1, acc1);
    do_op(0, 16'h8000, 16'h8000, 0, 16'h0000, 1'b1, 1'b1, acc2);
    chk("accept interval", 32'(acc2 - acc1), 32'd6);
    do_op(0, 16'hFFFF, 16'hFFFF, 5, 16'hFFFE, 1'b1, 1'b0, acc1);

    // Asynchronous reset in the second RUN cycle.
    issue(0, 16'h7777, 16'h1111, acc1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async rst in_ready", 32'(in_ready[0]), 32'd1);
    chk("async rst out_valid", 32'(out_valid[0]), 32'd0);
    chk("async rst busy", 32'(busy[0]), 32'd0);
    chk("async rst sum", 32'(sum_w[0]), 32'd0);
    chk("async rst carry_out", 32'(carry_out[0]), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      chk("no result after reset", 32'(out_valid[0]), 32'd0);
    end
    do_op(0, 16'h0001, 16'h0002, 0, 16'h0003, 1'b0, 1'b0, acc1);

    do_op(1, 16'h0009, 16'h0008, 0, 16'h0001, 1'b1, 1'b0, acc1);
    do_op(1, 16'h0007, 16'h0008, 2, 16'h000F, 1'b0, 1'b0, acc1);

    // Random traffic on both instances; the compare process does the checking.
    repeat (400) begin
      @(posedge clk); #2;
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = 1'($urandom);
        a[k]         = pick();
        b[k]         = pick();
        out_ready[k] = ($urandom % 3) != 0;
      end
    end
    @(posedge clk); #2;
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
    repeat (8) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
